// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared op encodings, FSM state encoding and default
// width for the iterative multiply/divide unit.
package mult_div_unit_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = 6;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  // Bit 0 of the op code selects the signed flavour, bit 1 selects divide.
  function automatic logic op_is_signed(input logic [1:0] op_v);
    return op_v[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op_v);
    return op_v[1];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational sign handling for the multiply/divide unit.
// On entry it turns raw operands into magnitudes; in FIX it negates the
// product / quotient and gives the remainder the dividend's sign.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     rs_i,
  input  logic [WIDTH-1:0]     rt_i,
  output logic [WIDTH-1:0]     rs_mag_o,
  output logic [WIDTH-1:0]     rt_mag_o,
  output logic                 rs_neg_o,
  output logic                 rt_neg_o,
  input  logic                 is_div_i,
  input  logic                 neg_res_i,
  input  logic                 neg_rem_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  output logic [2*WIDTH-1:0]   res_o
);

  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] quot_s;

  // Entry: operand sign bits and two's-complement magnitudes.
  always_comb begin
    rs_neg_o = signed_i & rs_i[WIDTH-1];
    rt_neg_o = signed_i & rt_i[WIDTH-1];
    if (rs_neg_o) begin
      rs_mag_o = ~rs_i + WIDTH'(1);
    end else begin
      rs_mag_o = rs_i;
    end
    if (rt_neg_o) begin
      rt_mag_o = ~rt_i + WIDTH'(1);
    end else begin
      rt_mag_o = rt_i;
    end
  end

  // Exit: sign correction of the unsigned iteration result.
  always_comb begin
    rem_s  = acc_i[2*WIDTH-1:WIDTH];
    quot_s = acc_i[WIDTH-1:0];
    if (is_div_i) begin
      if (neg_rem_i) begin
        res_o[2*WIDTH-1:WIDTH] = ~rem_s + WIDTH'(1);
      end else begin
        res_o[2*WIDTH-1:WIDTH] = rem_s;
      end
      if (neg_res_i) begin
        res_o[WIDTH-1:0] = ~quot_s + WIDTH'(1);
      end else begin
        res_o[WIDTH-1:0] = quot_s;
      end
    end else begin
      if (neg_res_i) begin
        res_o = ~acc_i + (2*WIDTH)'(1);
      end else begin
        res_o = acc_i;
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO.
// One shift-add or restoring-divide step per clock over WIDTH clocks,
// followed by a sign-fix cycle and a one-cycle DONE pulse.
// Optional macro MDU_HILO_WRITE_EN adds MTHI/MTLO write ports.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = MDU_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
`ifdef MDU_HILO_WRITE_EN
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e           state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 div_zero_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  // acc_q: multiply = {partial product, multiplier}; divide = {remainder, dividend/quotient}
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opd_q;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]     rs_raw_q;  // unmodified dividend for divide-by-zero
  logic                 is_div_q;
  logic                 neg_res_q;
  logic                 neg_rem_q;
  logic                 dz_q;

  logic [WIDTH-1:0]     rs_mag_s;
  logic [WIDTH-1:0]     rt_mag_s;
  logic                 rs_neg_s;
  logic                 rt_neg_s;
  logic [2*WIDTH-1:0]   res_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH:0]       div_trial_s;
  logic [2*WIDTH-1:0]   step_s;

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .signed_i  (op_is_signed(op)),
    .rs_i      (rs_data),
    .rt_i      (rt_data),
    .rs_mag_o  (rs_mag_s),
    .rt_mag_o  (rt_mag_s),
    .rs_neg_o  (rs_neg_s),
    .rt_neg_o  (rt_neg_s),
    .is_div_i  (is_div_q),
    .neg_res_i (neg_res_q),
    .neg_rem_i (neg_rem_q),
    .acc_i     (acc_q),
    .res_o     (res_s)
  );

  // One datapath iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    if (acc_q[0]) begin
      mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
    end else begin
      mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    end
    div_shift_s = acc_q[2*WIDTH-1:WIDTH-1];
    div_trial_s = div_shift_s - {1'b0, opd_q};
    if (is_div_q) begin
      if (!div_trial_s[WIDTH]) begin
        step_s = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        step_s = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    end
  end

  // Control FSM with registered busy/done/div_zero and HI/LO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_q      <= '0;
      opd_q      <= '0;
      rs_raw_q   <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
`ifdef MDU_HILO_WRITE_EN
          if (hilo_we) begin
            if (hilo_sel) begin
              hi_q <= hilo_wdata;
            end else begin
              lo_q <= hilo_wdata;
            end
          end
`endif
          if (start) begin
            is_div_q   <= op_is_div(op);
            neg_res_q  <= rs_neg_s ^ rt_neg_s;
            neg_rem_q  <= rs_neg_s;
            dz_q       <= op_is_div(op) && (rt_data == '0);
            rs_raw_q   <= rs_data;
            div_zero_q <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_RUN;
            if (op_is_div(op)) begin
              opd_q <= rt_mag_s;
              acc_q <= {{WIDTH{1'b0}}, rs_mag_s};
            end else begin
              opd_q <= rs_mag_s;
              acc_q <= {{WIDTH{1'b0}}, rt_mag_s};
            end
          end
        end
        ST_RUN: begin
          acc_q <= step_s;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (dz_q) begin
            hi_q       <= rs_raw_q;
            lo_q       <= {WIDTH{1'b1}};
            div_zero_q <= 1'b1;
          end else begin
            hi_q <= res_s[2*WIDTH-1:WIDTH];
            lo_q <= res_s[WIDTH-1:0];
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven directed bench for mult_div_unit plus
// hand-written sequences for busy/done/reset corner cases.
// Exercises MDU_HILO_WRITE_EN writes when that macro is defined.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MDU_HILO_WRITE_EN
  logic        hilo_we;
  logic        hilo_sel;
  logic [31:0] hilo_wdata;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
`ifdef MDU_HILO_WRITE_EN
    .hilo_we    (hilo_we),
    .hilo_sel   (hilo_sel),
    .hilo_wdata (hilo_wdata),
`endif
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Launch one op at a negedge and wait (bounded) for done; lat = posedges until done seen.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; rs_data = $urandom; rt_data = $urandom;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: done not seen within %0d cycles", lat);
    end
  endtask

  initial begin
    int lat;
    int pulses;
    logic [31:0] cap_hi;
    logic [31:0] cap_lo;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'b10, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{2'b00, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0};
    vecs[5]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6]  = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[7]  = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{2'b11, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[10] = '{2'b00, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[11] = '{2'b01, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};
    vecs[12] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_data = 32'h0; rt_data = 32'h0;
`ifdef MDU_HILO_WRITE_EN
    hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = 32'h0;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_dz",   {31'b0, div_zero}, 32'h0);
    check("reset_hi",   hi, 32'h0);
    check("reset_lo",   lo, 32'h0);
    rst_n = 1'b1;

    // Table-driven operations
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d_dz", i), {31'b0, div_zero}, {31'b0, vecs[i].dz});
      check($sformatf("v%0d_latency", i), lat, 32'd34);
      check($sformatf("v%0d_busy_in_done", i), {31'b0, busy}, 32'h0);
    end

    // Start in the DONE cycle is ignored; hi/lo hold afterwards
    start = 1'b1; op = 2'b00; rs_data = 32'd5; rt_data = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("done_start_busy", {31'b0, busy}, 32'h0);
    check("done_pulse_width", {31'b0, done}, 32'h0);
    repeat (3) @(negedge clk);
    check("done_start_busy2", {31'b0, busy}, 32'h0);
    check("hold_hi", hi, 32'h0);
    check("hold_lo", lo, 32'hFFFF_FFFF);

    // Start while busy is ignored
    @(negedge clk);
    start = 1'b1; op = 2'b10; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0; rs_data = 32'h0; rt_data = 32'h0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b00; rs_data = 32'd9; rt_data = 32'd9;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; cap_hi = 32'hDEAD_DEAD; cap_lo = 32'hDEAD_DEAD;
    for (int c = 0; c < 80; c++) begin
      if (done) begin
        pulses++;
        cap_hi = hi;
        cap_lo = lo;
      end
      @(negedge clk);
    end
    check("busy_start_lo", cap_lo, 32'd14);
    check("busy_start_hi", cap_hi, 32'd2);
    check("busy_start_pulses", pulses, 32'd1);

    // Reset mid-operation aborts the op
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_data = 32'd1000; rt_data = 32'd1000;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    pulses = 0;
    for (int c = 0; c < 50; c++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", pulses, 32'd0);
    do_op(2'b00, 32'd2, 32'd3, lat);
    check("post_reset_lo", lo, 32'd6);
    check("post_reset_latency", lat, 32'd34);

`ifdef MDU_HILO_WRITE_EN
    // MTHI in IDLE, then a write while busy is ignored
    @(negedge clk);
    @(negedge clk);
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hCAFE_BABE;
    @(negedge clk);
    hilo_we = 1'b0;
    check("hilo_write_hi", hi, 32'hCAFE_BABE);
    start = 1'b1; op = 2'b00; rs_data = 32'd4; rt_data = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h1234_5678;
    @(negedge clk);
    hilo_we = 1'b0;
    check("hilo_busy_ignored", hi, 32'hCAFE_BABE);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("hilo_op_lo", lo, 32'd16);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
